// File: rtl/ysyx_22050368_ifu_if.sv
// Fetch-unit bus bundle: imem request/response channels and the
// inst/pc handshake towards decode. master = ifu side, slave = environment.
interface ysyx_22050368_ifu_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  // instruction-memory request channel (valid/ready)
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [ADDR_W-1:0] imem_req_addr_o;
  // instruction-memory response channel (valid only)
  logic              imem_rsp_valid_i;
  logic [INST_W-1:0] imem_rsp_data_i;
  logic              imem_rsp_err_i;
  // fetch -> decode handshake
  logic              if_valid_o;
  logic              if_ready_i;
  logic [INST_W-1:0] if_inst_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic              if_err_o;

  modport master (
    output imem_req_valid_o,
    output imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    input  imem_rsp_err_i,
    output if_valid_o,
    input  if_ready_i,
    output if_inst_o,
    output if_pc_o,
    output if_err_o
  );

  modport slave (
    input  imem_req_valid_o,
    input  imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    output imem_rsp_err_i,
    input  if_valid_o,
    output if_ready_i,
    input  if_inst_o,
    input  if_pc_o,
    input  if_err_o
  );
endinterface

// File: rtl/ysyx_22050368_ifu.sv
// Instruction fetch unit: one outstanding imem request, feeds decode.
// Ports: clk, rst (async active-low), jump/hold controls, bus (master).
module ysyx_22050368_ifu #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(64'h0000_0000_8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  ysyx_22050368_ifu_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              en_q;
  logic              vld_q, vld_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic              err_q, err_d;

  logic              req_hs;
  logic              out_hs;
  logic [ADDR_W-1:0] jmp_tgt;

  // en_q keeps the request line low until one cycle after reset release
  assign bus.imem_req_valid_o =
    en_q & (state_q == S_REQ) & ~hold_i;
  assign bus.imem_req_addr_o  = pc_q;
  assign bus.if_valid_o       = vld_q;
  assign bus.if_inst_o        = inst_q;
  assign bus.if_pc_o          = opc_q;
  assign bus.if_err_o         = err_q;

  assign req_hs  = bus.imem_req_valid_o & bus.imem_req_ready_i;
  assign out_hs  = vld_q & bus.if_ready_i;
  assign jmp_tgt = jump_addr_i & ~ADDR_W'(3);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    vld_d    = vld_q;
    inst_d   = inst_q;
    opc_d    = opc_q;
    err_d    = err_q;

    unique case (state_q)
      S_REQ: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(4);
          state_d  = S_WAIT;
          // the accepted request is for the old path
          if (jump_flag_i) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          if (drop_q || jump_flag_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = bus.imem_rsp_data_i;
            opc_d   = req_pc_q;
            err_d   = bus.imem_rsp_err_i;
            vld_d   = 1'b1;
            state_d = S_OUT;
          end
        end else if (jump_flag_i) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        // a jump kills the held instruction even if decode takes it
        if (out_hs || jump_flag_i) begin
          vld_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (jump_flag_i) begin
      pc_d  = jmp_tgt;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      inst_q   <= '0;
      opc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      en_q     <= 1'b1;
      vld_q    <= vld_d;
      inst_q   <= inst_d;
      opc_q    <= opc_d;
      err_q    <= err_d;
    end
  end

endmodule
